// File: rtl/serial_add_ctrl_if.sv
// Handshake bundle between the operand producer, the serial adder and the
// result consumer. The producer/consumer side uses the master modport, the
// adder uses the slave modport.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell: the single arithmetic element that the serial
// controller reuses for every bit position.
module full_adder (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. One full_adder is stepped over WIDTH cycles,
// LSB first, with operand shift registers feeding it and a result register
// collecting sum bits from the MSB end. Valid/ready on both sides; the result
// is presented in DONE and held until the consumer takes it.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_add_ctrl_if.slave      bus,
  output logic                  busy
);

  // Counter must be able to hold WIDTH-1; $clog2(WIDTH+1) keeps it >= 1 bit
  // even when WIDTH is 1.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_r;
  state_t state_s;

  // Datapath registers
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;

  // Registered handshake/status outputs and their next values
  logic in_ready_r;
  logic out_valid_r;
  logic busy_r;
  logic in_ready_s;
  logic out_valid_s;
  logic busy_s;

  // Full-adder hookup
  logic fa_sum_s;
  logic fa_cout_s;

  logic accept_s;
  logic last_bit_s;

  // The only arithmetic cell: operand LSBs plus the running carry.
  full_adder u_fa (
    .sum  (fa_sum_s),
    .cout (fa_cout_s),
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r)
  );

  assign accept_s   = bus.in_valid && in_ready_r;
  assign last_bit_s = (cnt_r == CW'(WIDTH - 1));

  // State register plus registered copies of the decoded outputs, so the
  // handshake pins come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
    end
  end

  // Next-state logic: accept in IDLE, step WIDTH bits in RUN, wait for the
  // consumer in DONE. No bypass from DONE straight into a new accept.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_bit_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode from the next state; the flops above make these visible in
  // the cycle that the state is entered.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (state_s)
      IDLE: begin
        in_ready_s = 1'b1;
      end
      RUN: begin
        busy_s = 1'b1;
      end
      DONE: begin
        out_valid_s = 1'b1;
        busy_s      = 1'b1;
      end
      default: begin
        in_ready_s = 1'b1;
      end
    endcase
  end

  // Datapath: load on accept, shift one bit per RUN cycle, hold otherwise so
  // sum/cout stay frozen for the whole of DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_sh_r  <= bus.a;
            b_sh_r  <= bus.b;
            carry_r <= bus.cin;
            cnt_r   <= {CW{1'b0}};
          end
        end
        RUN: begin
          // Sum bit enters at the MSB; after WIDTH shifts bit 0 of the
          // result sits at the LSB.
          res_r   <= (res_r >> 1) | (WIDTH'(fa_sum_s) << (WIDTH - 1));
          a_sh_r  <= a_sh_r >> 1;
          b_sh_r  <= b_sh_r >> 1;
          carry_r <= fa_cout_s;
          cnt_r   <= cnt_r + CW'(1);
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = res_r;
  assign bus.cout      = carry_r;
  assign busy          = busy_r;

endmodule
